// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory port between fetch (F) and a
// loader/debug port (L). Round-robin grant, at most one request per cycle,
// in-order owner FIFO routes each response back to its issuer, and a fetch
// redirect kills responses to fetch requests still in flight.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   f_req_* / f_flush / f_rsp_*      fetch request, redirect, response
//   l_req_* / l_rsp_*                loader request and response
//   mem_addr/_valid, mem_tag_out     memory request (always accepted)
//   mem_rdata/_valid, mem_tag_in     in-order memory response
//   orphan_err                       sticky: response with nothing outstanding
module imem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  input  logic [XLEN-1:0]   f_req_tag,
  input  logic              f_flush,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic [XLEN-1:0]   f_rsp_tag,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic [ADDR_W-1:0] l_req_addr,
  input  logic [XLEN-1:0]   l_req_tag,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rsp_data,
  output logic [XLEN-1:0]   l_rsp_tag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_addr_valid,
  output logic [XLEN-1:0]   mem_tag_out,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  input  logic [XLEN-1:0]   mem_tag_in,
  output logic              orphan_err
);

  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  // Owner FIFO: own_q bit 1 = loader, kill_q marks a fetch entry to drop.
  logic [MAX_OUT-1:0] own_q;
  logic [MAX_OUT-1:0] kill_q;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   cnt;
  logic               prio;   // 0: fetch wins a tie, 1: loader wins

  logic not_full;
  logic has_out;
  logic elig_f;
  logic elig_l;
  logic grant_f;
  logic grant_l;
  logic push;
  logic pop;
  logic head_own;
  logic head_kill;

  // Arbitration and response routing; readiness follows the registered count.
  always_comb begin
    not_full  = (cnt != CNT_W'(MAX_OUT));
    has_out   = (cnt != '0);
    elig_f    = f_req_valid & ~f_flush & not_full;
    elig_l    = l_req_valid & not_full;
    grant_f   = elig_f & (~elig_l | ~prio);
    grant_l   = elig_l & ~grant_f;
    push      = grant_f | grant_l;
    pop       = mem_rdata_valid & has_out;
    head_own  = own_q[rptr];
    head_kill = kill_q[rptr];

    f_req_ready    = grant_f;
    l_req_ready    = grant_l;
    mem_addr_valid = push;
    mem_addr       = '0;
    mem_tag_out    = '0;
    if (grant_f) begin
      mem_addr    = f_req_addr;
      mem_tag_out = f_req_tag;
    end else if (grant_l) begin
      mem_addr    = l_req_addr;
      mem_tag_out = l_req_tag;
    end

    // A fetch response coinciding with a flush is dropped as well.
    f_rsp_valid = pop & ~head_own & ~head_kill & ~f_flush;
    l_rsp_valid = pop & head_own;
    f_rsp_data  = f_rsp_valid ? mem_rdata  : '0;
    f_rsp_tag   = f_rsp_valid ? mem_tag_in : '0;
    l_rsp_data  = l_rsp_valid ? mem_rdata  : '0;
    l_rsp_tag   = l_rsp_valid ? mem_tag_in : '0;
  end

  // FIFO pointers, count, priority and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q      <= '0;
      kill_q     <= '0;
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      prio       <= 1'b0;
      orphan_err <= 1'b0;
    end else begin
      // Marking stale slots too is harmless: a push rewrites kill.
      if (f_flush) kill_q <= kill_q | ~own_q;
      if (push) begin
        own_q[wptr]  <= grant_l;
        kill_q[wptr] <= 1'b0;
        wptr         <= wptr + PTR_W'(1);
        prio         <= grant_f;
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (mem_rdata_valid & ~has_out) orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter with an in-order memory model and a
// queue-based reference of the outstanding requests.
module tb_imem_arbiter;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req_valid, f_req_ready, f_flush;
  logic [ADDR_W-1:0] f_req_addr;
  logic [XLEN-1:0]   f_req_tag;
  logic              f_rsp_valid;
  logic [DATA_W-1:0] f_rsp_data;
  logic [XLEN-1:0]   f_rsp_tag;
  logic              l_req_valid, l_req_ready;
  logic [ADDR_W-1:0] l_req_addr;
  logic [XLEN-1:0]   l_req_tag;
  logic              l_rsp_valid;
  logic [DATA_W-1:0] l_rsp_data;
  logic [XLEN-1:0]   l_rsp_tag;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_addr_valid;
  logic [XLEN-1:0]   mem_tag_out;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;
  logic [XLEN-1:0]   mem_tag_in;
  logic              orphan_err;

  imem_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_req_tag(f_req_tag), .f_flush(f_flush),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_tag(f_rsp_tag),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_addr(l_req_addr),
    .l_req_tag(l_req_tag),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data), .l_rsp_tag(l_rsp_tag),
    .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid), .mem_tag_out(mem_tag_out),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .mem_tag_in(mem_tag_in),
    .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  // One outstanding request as the spec sees it, plus what memory will return.
  typedef struct {
    bit                own_l;
    bit                kill;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   tag;
    int                cyc;
  } ent_t;

  ent_t q[$];
  bit   m_prio_l;
  bit   m_orphan;
  int   cyc;
  int   n_chk;
  int   n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a, ~a};
  endfunction

  task automatic clear_inputs();
    f_req_valid = 0; f_flush = 0; f_req_addr = '0; f_req_tag = '0;
    l_req_valid = 0; l_req_addr = '0; l_req_tag = '0;
    mem_rdata_valid = 0; mem_rdata = '0; mem_tag_in = '0;
  endtask

  // Reset for one cycle; memory is reset together with the block.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_prio_l = 0;
    m_orphan = 0;
    cyc += 2;
  endtask

  // One cycle: percentages for F valid, L valid, flush, memory response.
  task automatic step(input int pf, input int pl, input int pfl, input int pr,
                      input int lat, input bit inj_orphan);
    bit full, ef, el, gf, gl, rv;
    bit exp_f, exp_l;
    logic [ADDR_W-1:0] e_addr;
    logic [XLEN-1:0]   e_tag;
    @(negedge clk);
    f_req_valid = ($urandom_range(0, 99) < pf);
    l_req_valid = ($urandom_range(0, 99) < pl);
    f_flush     = ($urandom_range(0, 99) < pfl);
    f_req_addr  = ADDR_W'($urandom) & 16'hfffc;
    f_req_tag   = $urandom;
    l_req_addr  = ADDR_W'($urandom);
    l_req_tag   = $urandom;
    if (q.size() > 0)
      rv = (cyc >= q[0].cyc + lat) && ($urandom_range(0, 99) < pr);
    else
      rv = inj_orphan;
    mem_rdata_valid = rv;
    if (rv && q.size() > 0) begin
      mem_rdata  = mem_word(q[0].addr);
      mem_tag_in = q[0].tag;
    end else begin
      mem_rdata  = $urandom;
      mem_tag_in = $urandom;
    end
    #1;
    full = (q.size() == MAX_OUT);
    ef   = f_req_valid && !f_flush && !full;
    el   = l_req_valid && !full;
    gf   = ef && (!el || !m_prio_l);
    gl   = el && !gf;
    e_addr = gf ? f_req_addr : (gl ? l_req_addr : '0);
    e_tag  = gf ? f_req_tag  : (gl ? l_req_tag  : '0);
    exp_f = 0;
    exp_l = 0;
    if (rv && q.size() > 0) begin
      if (q[0].own_l) exp_l = 1;
      else if (!q[0].kill && !f_flush) exp_f = 1;
    end
    check_eq("f_req_ready", 64'(f_req_ready), 64'(gf));
    check_eq("l_req_ready", 64'(l_req_ready), 64'(gl));
    check_eq("mem_addr_valid", 64'(mem_addr_valid), 64'(gf || gl));
    check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
    check_eq("mem_tag_out", 64'(mem_tag_out), 64'(e_tag));
    check_eq("f_rsp_valid", 64'(f_rsp_valid), 64'(exp_f));
    check_eq("f_rsp_data", 64'(f_rsp_data), exp_f ? 64'(mem_word(q[0].addr)) : 64'(0));
    check_eq("f_rsp_tag", 64'(f_rsp_tag), exp_f ? 64'(q[0].tag) : 64'(0));
    check_eq("l_rsp_valid", 64'(l_rsp_valid), 64'(exp_l));
    check_eq("l_rsp_data", 64'(l_rsp_data), exp_l ? 64'(mem_word(q[0].addr)) : 64'(0));
    check_eq("l_rsp_tag", 64'(l_rsp_tag), exp_l ? 64'(q[0].tag) : 64'(0));
    check_eq("orphan_err", 64'(orphan_err), 64'(m_orphan));
    // Advance the reference to the state after the coming clock edge.
    if (rv) begin
      if (q.size() == 0) m_orphan = 1;
      else void'(q.pop_front());
    end
    if (f_flush) foreach (q[i]) if (!q[i].own_l) q[i].kill = 1;
    if (gf || gl) begin
      q.push_back('{own_l: gl, kill: 0, addr: e_addr, tag: e_tag, cyc: cyc});
      m_prio_l = gf;
    end
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    // Idle after reset: nothing granted, nothing returned.
    repeat (5) step(0, 0, 0, 0, 1, 0);
    // Fetch only, latency 2.
    repeat (300) step(90, 0, 0, 80, 2, 0);
    // Both requesters busy, latency 1: alternating grants.
    repeat (300) step(100, 100, 0, 100, 1, 0);
    // Memory stalled to reach the full condition, then drained.
    repeat (30) step(100, 50, 0, 0, 1, 0);
    repeat (60) step(100, 50, 0, 30, 1, 0);
    // Frequent redirects with mixed traffic and latency.
    for (int k = 1; k <= 3; k++) repeat (300) step(70, 50, 15, 60, k, 0);
    // Mid-operation reset with requests outstanding, then resume.
    repeat (20) step(100, 100, 0, 0, 1, 0);
    do_reset();
    repeat (300) step(60, 60, 10, 70, 2, 0);
    // Drain, then inject responses with nothing outstanding.
    repeat (40) step(0, 0, 0, 100, 1, 0);
    repeat (20) step(0, 0, 0, 100, 1, 1);
    repeat (100) step(60, 60, 10, 70, 1, 0);
    do_reset();
    repeat (200) step(80, 80, 10, 70, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: the fetch unit (requester F) and a loader/debug port (requester L), used for data-side reads of instruction memory and boot-time inspection.
- Issues at most one memory request per cycle using round-robin arbitration.
- Tracks outstanding requests in an in-order owner FIFO and routes each memory response back to the requester that issued it.
- On a fetch redirect, discards responses to fetch requests that are still in flight.

Parameters:
- XLEN, 32, width of the requester tags.
- ADDR_W, 16, instruction-memory address width.
- DATA_W, 32, instruction-memory read data width.
- MAX_OUT, 4, maximum outstanding memory requests; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- f_req_valid  in  1  fetch request.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_req_addr  in  ADDR_W  fetch address.
- f_req_tag  in  XLEN  fetch tag (PC).
- f_flush  in  1  fetch redirect; kills in-flight fetch responses.
- f_rsp_valid  out  1  fetch response.
- f_rsp_data  out  DATA_W  fetch response data.
- f_rsp_tag  out  XLEN  fetch response tag.
- l_req_valid  in  1  loader request.
- l_req_ready  out  1  loader request accepted this cycle.
- l_req_addr  in  ADDR_W  loader address.
- l_req_tag  in  XLEN  loader tag.
- l_rsp_valid  out  1  loader response.
- l_rsp_data  out  DATA_W  loader response data.
- l_rsp_tag  out  XLEN  loader response tag.
- mem_addr  out  ADDR_W  memory address.
- mem_addr_valid  out  1  memory request strobe; the memory always accepts it.
- mem_tag_out  out  XLEN  tag sent with the request.
- mem_rdata  in  DATA_W  memory read data.
- mem_rdata_valid  in  1  memory response; responses return in order, at least 1 cycle after the request.
- mem_tag_in  in  XLEN  tag returned with the response.
- orphan_err  out  1  sticky: a response arrived while no request was outstanding.

Behaviour:
- Owner FIFO:
  - MAX_OUT entries, each {owner (0=F, 1=L), kill}.
  - Registered count `cnt` in 0..MAX_OUT; push on grant, pop on mem_rdata_valid.
- Eligibility (combinational):
  - elig_f = f_req_valid & ~f_flush & (cnt < MAX_OUT).
  - elig_l = l_req_valid & (cnt < MAX_OUT).
- Arbitration:
  - Round-robin priority register `prio` (0=F first); resets to F.
  - Only one requester eligible: it is granted.
  - Both eligible: the `prio` side is granted.
  - After any grant, `prio` points to the non-granted requester.
- Grant outputs (same cycle, zero added latency):
  - f_req_ready / l_req_ready = grant to that requester.
  - mem_addr_valid = any grant; mem_addr and mem_tag_out are taken from the granted requester.
  - With no grant, mem_addr and mem_tag_out hold 0.
- Full condition:
  - cnt == MAX_OUT forces both ready signals and mem_addr_valid low.
  - A pop in the same cycle does not unblock that cycle; readiness follows the registered count.
- Response routing (combinational from mem_rdata_valid and the FIFO head):
  - head.owner==F & ~head.kill & ~f_flush: f_rsp_* = mem_rdata/mem_tag_in.
  - head.owner==L: l_rsp_* = mem_rdata/mem_tag_in (loader responses are never killed).
  - head.kill, or owner F with f_flush in that cycle: response is consumed silently; no rsp_valid is asserted.
  - Outputs are zero when their rsp_valid is low.
- Flush:
  - In the cycle f_flush is high, every valid FIFO entry with owner F gets kill=1 at the clock edge.
  - A fetch response arriving in that same cycle is also dropped.
  - Entries pushed in the flush cycle are necessarily L, because F is blocked.
- Simultaneous push and pop: cnt is unchanged; the write and read pointers both advance and wrap modulo MAX_OUT.
- Orphan response: mem_rdata_valid with cnt==0:
  - Dropped; no rsp_valid asserted; FIFO unchanged.
  - orphan_err set, cleared only by rst.
- Reset values:
  - cnt=0, pointers=0, prio=F, orphan_err=0.
  - All rsp_valid, ready and mem_addr_valid outputs low (they follow from cnt=0 and no valid inputs).
- Reset mid-operation:
  - The FIFO is cleared.
  - Responses to pre-reset requests that arrive after reset count as orphans and set orphan_err. The integrator must reset the memory together with this block.

Test Plan:
- Fetch only, MAX_OUT=4, memory latency 2, F requests at addr 0x0,0x4,0x8 back-to-back -> f_req_ready=1 each cycle, mem_addr sequence 0x0,0x4,0x8, f_rsp_tag returns 0x0,0x4,0x8 in order, l_rsp_valid never high.
- F and L both valid continuously, latency 1 -> grants alternate F,L,F,L starting with F after reset; each response is routed to its own port with the correct tag.
- Memory stalled with no responses, F valid -> 4 grants, then f_req_ready=0 and mem_addr_valid=0 with cnt=4; one response -> grant resumes the cycle after the pop, not the same cycle.
- F issues tags 0x100,0x104, L issues 0x20, then f_flush pulses before any response -> both fetch responses are dropped, l_rsp_valid with tag 0x20 is delivered, and no f_rsp_valid appears.
- f_flush and f_req_valid high together with L idle -> f_req_ready=0 and mem_addr_valid=0 that cycle; a fetch request the next cycle is granted and its response is delivered.
- mem_rdata_valid with no outstanding request -> no rsp_valid, orphan_err=1 and stays 1 until rst; rst asserted for 1 cycle -> orphan_err=0, cnt=0, prio=F.
